// File: rtl/perceptron_trainer.sv
// Teacher-side training sequencer: replays labelled samples into a perceptron each epoch and counts misclassifications.
// Optional per-sample error mask output is enabled with `define TRAINER_ERR_MASK_EN.
module perceptron_trainer #(
  parameter int DEPTH       = 8,
  parameter int ADDR_W      = 3,
  parameter int HOLD_CYCLES = 2,
  parameter int MAX_EPOCHS  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  input  logic [ADDR_W:0]   num_samples,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic [7:0]        epoch_count,
  output logic [ADDR_W:0]   err_count,
  output logic [3:0]        p_in1,
  output logic [3:0]        p_in2,
  output logic [6:0]        p_in3,
  output logic              p_desired_out,
  input  logic              p_out
`ifdef TRAINER_ERR_MASK_EN
  ,
  output logic [DEPTH-1:0]  err_mask
`endif
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] IDX_ZERO  = ADDR_W'(0);
  localparam logic [7:0]        MAX_C     = 8'(MAX_EPOCHS);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DRIVE     = 2'd1,
    ST_EPOCH_END = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic [ADDR_W:0]   acc_q, acc_d;
  logic [ADDR_W:0]   err_q, err_d;
  logic [7:0]        epoch_q, epoch_d;
  logic              conv_q, conv_d;
  logic [15:0]       sample_q, sample_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [ADDR_W:0]   start_n_s;
  logic [15:0]       first_sample_s;
  logic [ADDR_W-1:0] idx_next_s;
  logic              last_s;
  logic              hold_last_s;
  logic              mismatch_s;

  assign start_n_s      = (num_samples > DEPTH_C) ? DEPTH_C : num_samples;
  // A write landing in the same cycle as start must be visible to sample 0.
  assign first_sample_s = (wr_en && (wr_addr == IDX_ZERO)) ? wr_data : mem_q[IDX_ZERO];
  assign idx_next_s     = idx_q + IDX_ONE;
  assign last_s         = (({1'b0, idx_q} + CNT_ONE) == n_q);
  assign hold_last_s    = (hold_q == HOLD_LAST);
  assign mismatch_s     = (p_out != sample_q[0]);

  // Sample memory: written only while idle, never reset.
  always_ff @(posedge clk) begin
    if ((state_q == ST_IDLE) && wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Next-state and next-output logic for the training sequencer.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    hold_d   = hold_q;
    n_d      = n_q;
    acc_d    = acc_q;
    err_d    = err_q;
    epoch_d  = epoch_q;
    conv_d   = conv_q;
    sample_d = sample_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          n_d     = start_n_s;
          acc_d   = '0;
          err_d   = '0;
          epoch_d = 8'd0;
          conv_d  = 1'b0;
          idx_d   = '0;
          hold_d  = '0;
          if (start_n_s == '0) begin
            state_d  = ST_DONE;
            sample_d = 16'd0;
          end else begin
            state_d  = ST_DRIVE;
            sample_d = first_sample_s;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (hold_last_s) begin
          hold_d = '0;
          if (mismatch_s) begin
            acc_d = acc_q + CNT_ONE;
          end else begin
            acc_d = acc_q;
          end
          if (last_s) begin
            state_d  = ST_EPOCH_END;
            sample_d = 16'd0;
          end else begin
            idx_d    = idx_next_s;
            sample_d = mem_q[idx_next_s];
          end
        end else begin
          hold_d = hold_q + HOLD_ONE;
        end
      end
      ST_EPOCH_END: begin
        err_d   = acc_q;
        epoch_d = epoch_q + 8'd1;
        acc_d   = '0;
        if (acc_q == '0) begin
          conv_d  = 1'b1;
          state_d = ST_DONE;
        end else if ((epoch_q + 8'd1) == MAX_C) begin
          state_d = ST_DONE;
        end else begin
          idx_d    = '0;
          hold_d   = '0;
          sample_d = mem_q[IDX_ZERO];
          state_d  = ST_DRIVE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        sample_d = 16'd0;
      end
    endcase
    busy_d = (state_d == ST_DRIVE) || (state_d == ST_EPOCH_END);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      hold_q   <= '0;
      n_q      <= '0;
      acc_q    <= '0;
      err_q    <= '0;
      epoch_q  <= 8'd0;
      conv_q   <= 1'b0;
      sample_q <= 16'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      hold_q   <= hold_d;
      n_q      <= n_d;
      acc_q    <= acc_d;
      err_q    <= err_d;
      epoch_q  <= epoch_d;
      conv_q   <= conv_d;
      sample_q <= sample_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifdef TRAINER_ERR_MASK_EN
  logic [DEPTH-1:0] mask_acc_q, mask_acc_d;
  logic [DEPTH-1:0] mask_q, mask_d;

  // Per-sample error bits gathered during an epoch, published at epoch end.
  always_comb begin
    mask_acc_d = mask_acc_q;
    mask_d     = mask_q;
    if ((state_q == ST_IDLE) && start) begin
      mask_acc_d = '0;
      mask_d     = '0;
    end else if ((state_q == ST_DRIVE) && hold_last_s && mismatch_s) begin
      mask_acc_d[idx_q] = 1'b1;
    end else if (state_q == ST_EPOCH_END) begin
      mask_d     = mask_acc_q;
      mask_acc_d = '0;
    end else begin
      mask_acc_d = mask_acc_q;
    end
  end

  // Error mask registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_acc_q <= '0;
      mask_q     <= '0;
    end else begin
      mask_acc_q <= mask_acc_d;
      mask_q     <= mask_d;
    end
  end

  assign err_mask = mask_q;
`endif

  assign busy          = busy_q;
  assign done          = done_q;
  assign converged     = conv_q;
  assign epoch_count   = epoch_q;
  assign err_count     = err_q;
  assign p_in1         = sample_q[15:12];
  assign p_in2         = sample_q[11:8];
  assign p_in3         = sample_q[7:1];
  assign p_desired_out = sample_q[0];

endmodule

// File: tb/tb_perceptron_trainer.sv
// Scoreboard bench for perceptron_trainer: run results queued at start, checked by a monitor on each done pulse.
module tb_perceptron_trainer;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [15:0]       wr_data = 16'd0;
  logic [ADDR_W:0]   num_samples = '0;
  logic              start = 1'b0;
  logic              busy, done, converged;
  logic [7:0]        epoch_count;
  logic [ADDR_W:0]   err_count;
  logic [3:0]        p_in1, p_in2;
  logic [6:0]        p_in3;
  logic              p_desired_out;
  logic              p_out = 1'b0;
`ifdef TRAINER_ERR_MASK_EN
  logic [DEPTH-1:0]  err_mask;
`endif

  int total = 0;
  int bad   = 0;
  int mode  = 0;  // 0 perfect, 1 stuck at 0, 2 wrong on in1==3 during first two epochs

  typedef struct packed {
    logic       conv;
    logic [7:0] ep;
    logic [3:0] err;
    logic [15:0] cyc;
  } exp_t;
  exp_t exp_q[$];
  logic [15:0] busy_cyc = 16'd0;

  perceptron_trainer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .HOLD_CYCLES(2), .MAX_EPOCHS(3)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .num_samples(num_samples), .start(start), .busy(busy), .done(done),
    .converged(converged), .epoch_count(epoch_count), .err_count(err_count),
    .p_in1(p_in1), .p_in2(p_in2), .p_in3(p_in3), .p_desired_out(p_desired_out),
    .p_out(p_out)
`ifdef TRAINER_ERR_MASK_EN
    , .err_mask(err_mask)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural perceptron: output registered one cycle after its inputs.
  always @(posedge clk) begin
    if (mode == 1) p_out <= 1'b0;
    else if (mode == 2 && p_in1 == 4'd3 && epoch_count < 8'd2) p_out <= ~p_desired_out;
    else p_out <= p_desired_out;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: counts busy cycles and checks each run result against the queue.
  always @(negedge clk) begin
    if (!reset) begin
      busy_cyc <= 16'd0;
    end else begin
      if (busy) busy_cyc <= busy_cyc + 16'd1;
      if (done) begin
        busy_cyc <= 16'd0;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("converged", {31'd0, converged}, {31'd0, e.conv});
          chk("epoch_count", {24'd0, epoch_count}, {24'd0, e.ep});
          chk("err_count", {28'd0, err_count}, {28'd0, e.err});
          chk("busy_cycles", {16'd0, busy_cyc}, {16'd0, e.cyc});
        end
      end
    end
  end

  function automatic logic [15:0] mk(input logic [3:0] in1, input logic d);
    return {in1, 4'd5, 7'd9, d};
  endfunction

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [15:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic start_run(input logic [ADDR_W:0] n, input logic do_wr, input logic [15:0] d);
    @(negedge clk);
    num_samples = n; start = 1'b1;
    wr_en = do_wr; wr_addr = '0; wr_data = d;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    for (k = 0; k < 500; k++) begin
      if (done) break;
      @(negedge clk);
    end
    if (k == 500) chk({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic wait_epoch(input logic [7:0] ep, input string name);
    int k;
    for (k = 0; k < 500; k++) begin
      if (epoch_count == ep && busy) break;
      @(negedge clk);
    end
    if (k == 500) chk({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  function automatic exp_t mkexp(input logic c, input logic [7:0] ep, input logic [3:0] er, input logic [15:0] cy);
    exp_t e;
    e.conv = c; e.ep = ep; e.err = er; e.cyc = cy;
    return e;
  endfunction

  initial begin
    #12;
    chk("reset_outputs", {busy, done, converged, epoch_count, err_count, p_in1, p_in2, p_in3, p_desired_out},
        32'd0);
    reset = 1'b1;

    // Perfect model, 4 samples: one epoch of 9 busy cycles.
    for (int i = 0; i < 4; i++) wr(ADDR_W'(i), mk(4'(i + 1), i[0]));
    mode = 0;
    exp_q.push_back(mkexp(1'b1, 8'd1, 4'd0, 16'd9));
    start_run(4'd0 + 4'd4, 1'b0, 16'd0);
    wait_done("perfect");

    // Empty run.
    exp_q.push_back(mkexp(1'b0, 8'd0, 4'd0, 16'd0));
    start_run(4'd0, 1'b0, 16'd0);
    wait_done("empty");

    // Learns in epoch 3.
    mode = 2;
    exp_q.push_back(mkexp(1'b1, 8'd3, 4'd0, 16'd27));
    start_run(4'd4, 1'b0, 16'd0);
    wait_epoch(8'd2, "learn_ep2");
    chk("learn_err_after_ep2", {28'd0, err_count}, 32'd1);
`ifdef TRAINER_ERR_MASK_EN
    chk("learn_mask_after_ep2", {24'd0, err_mask}, 32'h4);
`endif
    wait_done("learn");
`ifdef TRAINER_ERR_MASK_EN
    chk("learn_mask_at_done", {24'd0, err_mask}, 32'h0);
`endif

    // Clamp to 8 samples, with a write to addr 0 in the start cycle.
    for (int i = 4; i < 8; i++) wr(ADDR_W'(i), mk(4'(i + 1), 1'b1));
    mode = 0;
    exp_q.push_back(mkexp(1'b1, 8'd1, 4'd0, 16'd17));
    start_run(4'd12, 1'b1, mk(4'hA, 1'b0));
    chk("start_write_bypass", {28'd0, p_in1}, 32'hA);
    wait_done("clamp");

    // Never learns: labels all 1, output stuck at 0.
    for (int i = 0; i < 4; i++) wr(ADDR_W'(i), mk(4'(i + 1), 1'b1));
    mode = 1;
    exp_q.push_back(mkexp(1'b0, 8'd3, 4'd4, 16'd27));
    start_run(4'd4, 1'b0, 16'd0);
    wait_done("never");

    // Write and start during a run are ignored.
    exp_q.push_back(mkexp(1'b0, 8'd3, 4'd4, 16'd27));
    start_run(4'd4, 1'b0, 16'd0);
    repeat (3) @(negedge clk);
    wr_en = 1'b1; wr_addr = '0; wr_data = mk(4'hF, 1'b0); start = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
    wait_epoch(8'd1, "ignore_ep2");
    chk("ignored_write_p_in1", {28'd0, p_in1}, 32'd1);
    wait_done("ignore");

    // Reset in the middle of epoch 2.
    start_run(4'd4, 1'b0, 16'd0);
    wait_epoch(8'd1, "rst_ep2");
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
    chk("rst_p_outputs", {16'd0, p_in1, p_in2, p_in3, p_desired_out}, 32'd0);
    chk("rst_epoch_count", {24'd0, epoch_count}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    mode = 0;
    exp_q.push_back(mkexp(1'b1, 8'd1, 4'd0, 16'd9));
    start_run(4'd4, 1'b0, 16'd0);
    chk("post_rst_epoch_start", {24'd0, epoch_count}, 32'd0);
    wait_done("post_rst");

    @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
